// File: rtl/clock_switch_sequencer.sv
// Reference-clock selection controller: picks the active clock by priority, manual override
// and revertive hold-off, and wraps each switchover in a guarded downstream reset.
module clock_switch_sequencer #(
  parameter int NumberOfClocks_Gen = 4,
  parameter int GuardCycles_Gen    = 16,
  parameter int SettleCycles_Gen   = 64,
  parameter int RevertHoldoff_Gen  = 1000
) (
  input  logic                          SysClk_ClkIn,
  input  logic                          SysRst_RstIn,
  input  logic [NumberOfClocks_Gen-1:0] ClockAvailable_DatIn,
  input  logic [NumberOfClocks_Gen-1:0] ClockManualSelect_DatIn,
  input  logic                          RevertEnable_EnIn,
  output logic [NumberOfClocks_Gen-1:0] ClkSelected_DatOut,
  output logic                          ClkMux1Select_EnOut,
  output logic                          ClkMux2Select_EnOut,
  output logic                          ClkMux3Select_EnOut,
  output logic                          ClkWiz2Select_EnOut,
  output logic                          ClockRstN_RstOut,
  output logic                          Busy_ValOut,
  output logic                          LossOfClock_EvtOut,
  output logic [15:0]                   SwitchCount_CntOut
);
  localparam int N      = NumberOfClocks_Gen;
  localparam int CntMax = (GuardCycles_Gen > SettleCycles_Gen) ? GuardCycles_Gen : SettleCycles_Gen;
  localparam int CntW   = $clog2(CntMax + 1);
  localparam int HoldW  = $clog2(RevertHoldoff_Gen + 1);

  typedef enum logic [2:0] {
    ST_IDLE, ST_QUALIFY, ST_GUARD, ST_SWITCH, ST_SETTLE
  } state_t;

  state_t            state_q, state_d;
  logic [N-1:0]      sel_q, sel_d;
  logic [N-1:0]      pending_q, pending_d;
  logic [N-1:0]      entry_q, entry_d;
  logic [N-1:0]      avail_q;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [HoldW-1:0]  hold_q, hold_d;
  logic [15:0]       swcnt_q, swcnt_d;
  logic              rstn_q, busy_q, loss_q;
  logic              mux1_q, mux2_q, mux3_q, wiz2_q;

  logic [N-1:0]      man_low, avail_low, target;
  logic              cur_lost, forced, target_higher, loss_evt;

  // x & -x isolates the lowest set bit, i.e. the highest-priority request.
  always_comb begin
    man_low       = ClockManualSelect_DatIn & (~ClockManualSelect_DatIn + N'(1));
    avail_low     = ClockAvailable_DatIn & (~ClockAvailable_DatIn + N'(1));
    target        = ((man_low & ClockAvailable_DatIn) != '0) ? man_low : avail_low;
    cur_lost      = (sel_q & ClockAvailable_DatIn) == '0;
    forced        = cur_lost || (ClockManualSelect_DatIn != '0 && target != sel_q);
    target_higher = (target != '0) && (target < sel_q);
    loss_evt      = (sel_q & avail_q & ~ClockAvailable_DatIn) != '0;
  end

  // NOTE: every next-state signal gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    pending_d = pending_q;
    entry_d   = entry_q;
    cnt_d     = cnt_q;
    hold_d    = hold_q;
    swcnt_d   = swcnt_q;
    case (state_q)
      ST_IDLE: begin
        if (target != sel_q) begin
          if (forced) begin
            state_d   = ST_GUARD;
            pending_d = target;
            cnt_d     = '0;
          end else if (RevertEnable_EnIn && target_higher) begin
            state_d = ST_QUALIFY;
            entry_d = target;
            hold_d  = '0;
          end
        end
      end
      ST_QUALIFY: begin
        if (cur_lost) begin
          state_d   = ST_GUARD;
          pending_d = target;
          cnt_d     = '0;
        end else if (target != entry_q || !target_higher) begin
          state_d = ST_IDLE;
        end else if (hold_q == HoldW'(RevertHoldoff_Gen - 1)) begin
          state_d   = ST_GUARD;
          pending_d = target;
          cnt_d     = '0;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      ST_GUARD: begin
        if (cnt_q == CntW'(GuardCycles_Gen - 1)) begin
          state_d = ST_SWITCH;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_SWITCH: begin
        sel_d   = pending_q;
        swcnt_d = (swcnt_q == 16'hFFFF) ? swcnt_q : swcnt_q + 16'd1;
        state_d = ST_SETTLE;
        cnt_d   = '0;
      end
      ST_SETTLE: begin
        if (cnt_q == CntW'(SettleCycles_Gen - 1)) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only; outputs are registered from the _d values.
  always_ff @(posedge SysClk_ClkIn) begin
    if (SysRst_RstIn) begin
      state_q   <= ST_SETTLE;
      sel_q     <= '0;
      pending_q <= '0;
      entry_q   <= '0;
      avail_q   <= '0;
      cnt_q     <= '0;
      hold_q    <= '0;
      swcnt_q   <= '0;
      rstn_q    <= 1'b0;
      busy_q    <= 1'b1;
      loss_q    <= 1'b0;
      mux1_q    <= 1'b0;
      mux2_q    <= 1'b0;
      mux3_q    <= 1'b0;
      wiz2_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      pending_q <= pending_d;
      entry_q   <= entry_d;
      avail_q   <= ClockAvailable_DatIn;
      cnt_q     <= cnt_d;
      hold_q    <= hold_d;
      swcnt_q   <= swcnt_d;
      rstn_q    <= (state_d == ST_IDLE) || (state_d == ST_QUALIFY);
      busy_q    <= (state_d != ST_IDLE);
      loss_q    <= loss_evt;
      // Board mux wiring assumes the four-clock arrangement (Sma, Mac, Dcxo1, Dcxo2).
      mux1_q    <= sel_d[1];
      mux2_q    <= sel_d[3];
      mux3_q    <= sel_d[2] | sel_d[3];
      wiz2_q    <= (sel_d == '0);
    end
  end

  assign ClkSelected_DatOut  = sel_q;
  assign ClkMux1Select_EnOut = mux1_q;
  assign ClkMux2Select_EnOut = mux2_q;
  assign ClkMux3Select_EnOut = mux3_q;
  assign ClkWiz2Select_EnOut = wiz2_q;
  assign ClockRstN_RstOut    = rstn_q;
  assign Busy_ValOut         = busy_q;
  assign LossOfClock_EvtOut  = loss_q;
  assign SwitchCount_CntOut  = swcnt_q;
endmodule

// File: tb/tb_clock_switch_sequencer.sv
// Directed bench for clock_switch_sequencer with short guard/settle/holdoff values.
module tb_clock_switch_sequencer;
  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  avail, man;
  logic        rev;
  logic [3:0]  sel;
  logic        mux1, mux2, mux3, wiz2, rstn, busy, loss;
  logic [15:0] swcnt;

  int checks = 0;
  int errors = 0;

  clock_switch_sequencer #(
    .NumberOfClocks_Gen(4),
    .GuardCycles_Gen(4),
    .SettleCycles_Gen(8),
    .RevertHoldoff_Gen(20)
  ) dut (
    .SysClk_ClkIn(clk),
    .SysRst_RstIn(rst),
    .ClockAvailable_DatIn(avail),
    .ClockManualSelect_DatIn(man),
    .RevertEnable_EnIn(rev),
    .ClkSelected_DatOut(sel),
    .ClkMux1Select_EnOut(mux1),
    .ClkMux2Select_EnOut(mux2),
    .ClkMux3Select_EnOut(mux3),
    .ClkWiz2Select_EnOut(wiz2),
    .ClockRstN_RstOut(rstn),
    .Busy_ValOut(busy),
    .LossOfClock_EvtOut(loss),
    .SwitchCount_CntOut(swcnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Called on the first sampled cycle of Guard; walks the reset-low window.
  task automatic finish_switch(input string tag, input logic [3:0] exp_sel, input int exp_loss);
    logic [3:0] old;
    int low, chg, losses;
    old = sel; low = 0; chg = -1; losses = 0;
    while (rstn == 1'b0 && low < 200) begin
      if (chg < 0 && sel != old) chg = low;
      if (loss) losses++;
      low++;
      @(negedge clk);
    end
    check({tag, "_rst_low"}, low, 13);
    check({tag, "_latency"}, chg, 5);
    check({tag, "_loss"}, losses, exp_loss);
    check({tag, "_sel"}, sel, exp_sel);
    check({tag, "_busy"}, busy, 0);
  endtask

  initial begin
    int q;
    rst = 1'b1; avail = 4'b0000; man = 4'b0000; rev = 1'b0;
    tick(2);
    check("rst_sel", sel, 0);
    check("rst_wiz2", wiz2, 1);
    check("rst_mux", {mux1, mux2, mux3}, 0);
    check("rst_rstn", rstn, 0);
    check("rst_busy", busy, 1);
    check("rst_loss", loss, 0);
    check("rst_swcnt", swcnt, 0);
    rst = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      tick(1);
      check($sformatf("post_rst_rstn_%0d", i), rstn, (i == 8) ? 1 : 0);
    end
    check("post_rst_busy", busy, 0);
    check("post_rst_sel", sel, 0);

    // First clock appears: forced switch from none.
    avail = 4'b0100;
    tick(1);
    check("t2_guard_busy", busy, 1);
    finish_switch("t2", 4'b0100, 0);
    check("t2_mux", {mux1, mux2, mux3, wiz2}, 4'b0010);
    check("t2_swcnt", swcnt, 1);

    // Revertive switch after 20 qualify cycles.
    rev = 1'b1; avail = 4'b0101;
    q = 1;
    tick(1);
    check("t3a_qual_rstn", rstn, 1);
    check("t3a_qual_busy", busy, 1);
    while (rstn == 1'b1 && q < 100) begin
      tick(1);
      q++;
    end
    check("t3a_holdoff", q, 21);
    finish_switch("t3a", 4'b0001, 0);
    check("t3a_swcnt", swcnt, 2);

    // Back to 0100, then abort qualification at cycle 10.
    avail = 4'b0100;
    tick(1);
    finish_switch("restore", 4'b0100, 1);
    avail = 4'b0101;
    tick(10);
    avail = 4'b0100;
    tick(1);
    check("t3b_abort_busy", busy, 0);
    tick(30);
    check("t3b_sel", sel, 4'b0100);
    check("t3b_rstn", rstn, 1);
    check("t3b_swcnt", swcnt, 3);

    // Non-revertive: never leaves 0100.
    rev = 1'b0; avail = 4'b0101;
    tick(1);
    check("t3c_busy", busy, 0);
    tick(40);
    check("t3c_sel", sel, 4'b0100);
    check("t3c_swcnt", swcnt, 3);

    // Loss of current clock: immediate forced switch.
    avail = 4'b0011;
    tick(1);
    finish_switch("t4_setup", 4'b0001, 1);
    avail = 4'b0010;
    tick(1);
    check("t4_guard_rstn", rstn, 0);
    finish_switch("t4", 4'b0010, 1);
    check("t4_mux1", {mux1, mux2, mux3, wiz2}, 4'b1000);
    check("t4_swcnt", swcnt, 5);

    // Manual override, fallback when it vanishes, lowest manual bit wins.
    avail = 4'b1111; man = 4'b1000;
    tick(1);
    finish_switch("t5a", 4'b1000, 0);
    check("t5a_mux", {mux1, mux2, mux3, wiz2}, 4'b0110);
    avail = 4'b0111;
    tick(1);
    finish_switch("t5b", 4'b0001, 1);
    man = 4'b0110;
    tick(1);
    finish_switch("t5c", 4'b0010, 0);
    check("t5c_swcnt", swcnt, 8);

    // Target change during Guard is ignored; re-evaluated afterwards.
    man = 4'b0100;
    tick(1);
    man = 4'b0001;
    finish_switch("t6", 4'b0100, 0);
    tick(1);
    check("t6_reeval_rstn", rstn, 0);
    tick(6);
    check("t6_reeval_sel", sel, 4'b0001);
    check("t6_reeval_swcnt", swcnt, 10);

    // Reset mid-Settle.
    rst = 1'b1;
    tick(1);
    check("t6_rst_sel", sel, 0);
    check("t6_rst_rstn", rstn, 0);
    check("t6_rst_swcnt", swcnt, 0);
    check("t6_rst_busy", busy, 1);
    check("t6_rst_wiz2", wiz2, 1);
    rst = 1'b0; man = 4'b0000; avail = 4'b0000;
    tick(8);
    check("t6_final_busy", busy, 0);
    check("t6_final_rstn", rstn, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/clock_switch_sequencer.md
Name: clock_switch_sequencer

Overview:
Controller that picks the active 10 MHz reference from per-clock availability flags (priority, manual override, revertive hold-off) and sequences every switchover glitch-safely. Each switch holds downstream logic in reset, changes the mux selects, waits for the PLL to settle, then releases reset. It sits between the clock-availability detection logic and the board clock muxes / clock wizard select pins, and owns the downstream clock reset.

Parameters:
NumberOfClocks_Gen, 4, number of clock inputs; index 0 = highest priority (Sma, Mac, Dcxo1, Dcxo2).
GuardCycles_Gen, 16, SysClk cycles reset is held before the select change.
SettleCycles_Gen, 64, SysClk cycles reset is held after the select change.
RevertHoldoff_Gen, 1000, cycles a higher-priority clock must stay available before a revertive switch.

Ports:
SysClk_ClkIn  in  1  system clock; all logic is synchronous to it.
SysRst_RstIn  in  1  reset, synchronous, active-high.
ClockAvailable_DatIn  in  NumberOfClocks_Gen  per-clock availability, already synchronous to SysClk.
ClockManualSelect_DatIn  in  NumberOfClocks_Gen  manual request; 0 = automatic; if several bits are set, the lowest set index wins.
RevertEnable_EnIn  in  1  1 = revertive switching to a higher-priority clock is allowed.
ClkSelected_DatOut  out  NumberOfClocks_Gen  one-hot active clock; 0 = none (external/Wiz2).
ClkMux1Select_EnOut  out  1  equals ClkSelected[1].
ClkMux2Select_EnOut  out  1  equals ClkSelected[3].
ClkMux3Select_EnOut  out  1  equals ClkSelected[2] OR ClkSelected[3].
ClkWiz2Select_EnOut  out  1  1 when ClkSelected == 0.
ClockRstN_RstOut  out  1  downstream clock-domain reset, active-low.
Busy_ValOut  out  1  1 in any state other than Idle.
LossOfClock_EvtOut  out  1  one-cycle pulse on loss of the selected clock.
SwitchCount_CntOut  out  16  number of completed switches; saturates at 0xFFFF.

Behaviour:
- All outputs are registered. Mux and Wiz2 selects are decoded from the ClkSelected register.
- Target (combinational):
  - if ManualSelect != 0 and its lowest set bit is available, target is that one-hot;
  - else target is the lowest-index available clock;
  - else target is 0.
- Forced condition: current == 0, or the current clock is unavailable, or ManualSelect != 0 and target != current.
- States: Idle, Qualify, Guard, Switch, Settle.
- Idle:
  - target == current: stay in Idle.
  - target != current and forced: go to Guard; latch target into Pending.
  - target != current, not forced, RevertEnable=1, target higher priority than current: go to Qualify; clear the holdoff counter.
  - otherwise (not forced, RevertEnable=0 or target not higher priority): stay in Idle.
- Qualify, per cycle:
  - current lost: go to Guard with Pending = target (loss has priority).
  - else target changed from the value on entry, or target is no longer higher priority: go to Idle.
  - else counter reaches RevertHoldoff_Gen-1: go to Guard with Pending = target.
  - else increment the counter.
- Guard: ClockRstN=0 for exactly GuardCycles_Gen cycles, then go to Switch. Pending is frozen; input changes are ignored.
- Switch: one cycle. ClkSelected <= Pending (visible from the first Settle cycle). SwitchCount increments, saturating.
- Settle: ClockRstN=0 for exactly SettleCycles_Gen cycles, then go to Idle. ClockRstN=1 is visible in the first Idle cycle.
- Resulting timing:
  - ClockRstN is 0 in Guard, Switch and Settle; 1 in Idle and Qualify.
  - Switch latency: the select changes GuardCycles_Gen+1 cycles after Guard entry.
  - Reset pulse width: GuardCycles_Gen+1+SettleCycles_Gen cycles.
- LossOfClock_EvtOut: single-cycle pulse when current != 0 and its availability bit goes 1->0, in any state. It is not repeated while the clock stays lost.
- A clock lost during Guard or Settle does not abort the sequence; it is re-evaluated on return to Idle.
- Reset (SysRst_RstIn=1, sampled on a clock edge):
  - ClkSelected=0, Wiz2=1, Mux1/2/3=0, ClockRstN=0, Busy=1, LossOfClock=0, SwitchCount=0, counters=0.
  - The FSM enters Settle, so ClockRstN stays 0 for SettleCycles_Gen cycles after reset release.
  - Reset asserted mid-sequence discards Pending; reset values appear on the next edge.

Test Plan:
1. Guard=4, Settle=8, Revert=20; reset released with Available=0 -> ClkSelected=0, Wiz2=1, ClockRstN=0 for 8 cycles then 1, Busy then 0, SwitchCount=0.
2. Available=0100 in Idle -> Guard entered next cycle; ClkSelected=0100 (Mux3=1, Mux1=Mux2=0, Wiz2=0) 5 cycles later; ClockRstN low 13 cycles; SwitchCount=1.
3. Current 0100, bit0 rises, RevertEnable=1 -> switch to 0001 begins after 20 Qualify cycles. Repeat with bit0 dropping at Qualify cycle 10 -> back to Idle, no switch. Repeat with RevertEnable=0 -> stays on 0100 indefinitely.
4. Current 0001, Available 0011->0010 -> LossOfClock single pulse; Guard entered next cycle (no holdoff); final ClkSelected=0010 with Mux1=1.
5. Available=1111, Manual=1000 -> immediate switch to 1000 (Mux2=Mux3=1). Then bit3 drops -> fallback to 0001. Manual=0110 -> selects 0010.
6. Target changed during Guard -> the original Pending is applied. SysRst pulsed mid-Settle -> next edge shows ClkSelected=0, ClockRstN=0, SwitchCount=0, Busy=1.
